// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle RV32I control sequencer (fetch/decode/execute/memory/writeback)
// with memory handshakes, stall support and a sticky error trap.
`default_nettype none

module ctrl_seq #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = ($clog2(MEM_TIMEOUT + 1) < 1) ? 1 : $clog2(MEM_TIMEOUT + 1)
) (
    input  logic       clock,
    input  logic       reset,          // active-low, asynchronous
    input  logic [6:0] opcode,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    input  logic       branch_taken,
    input  logic       stall,
    input  logic       err_clear,
    output logic       imem_req,
    output logic       ir_load,
    output logic       alubuf1_load,
    output logic       alubuf2_load,
    output logic       alu_load,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       rf_write,
    output logic       pc_inc,
    output logic       pc_load,
    output logic [2:0] state_o,
    output logic       error,
    output logic [1:0] err_code
);

    typedef enum logic [2:0] {
        ST_ERROR     = 3'd0,
        ST_RESET     = 3'd1,
        ST_FETCH     = 3'd2,
        ST_DECODE    = 3'd3,
        ST_EXECUTE   = 3'd4,
        ST_MEMORY    = 3'd5,
        ST_WRITEBACK = 3'd6,
        ST_INVALID   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU    = 3'd0,
        CL_LOAD   = 3'd1,
        CL_STORE  = 3'd2,
        CL_BRANCH = 3'd3,
        CL_JUMP   = 3'd4
    } class_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t          state, state_next;
    class_t          cls, op_class;
    logic            op_legal;
    logic [TO_W-1:0] wait_cnt;
    logic [1:0]      err_next;
    logic            timeout_hit;

    always_comb begin
        op_class = CL_ALU;
        op_legal = 1'b1;
        case (opcode)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: op_class = CL_ALU;
            7'b0000011:                                     op_class = CL_LOAD;
            7'b0100011:                                     op_class = CL_STORE;
            7'b1100011:                                     op_class = CL_BRANCH;
            7'b1101111, 7'b1100111:                         op_class = CL_JUMP;
            default:                                        op_legal = 1'b0;
        endcase
    end

    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == TO_LAST);
    assign state_o     = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_RESET;
            cls      <= CL_ALU;
            wait_cnt <= '0;
            err_code <= 2'b00;
        end else begin
            state    <= state_next;
            err_code <= err_next;
            if (state == ST_DECODE && !stall && op_legal)
                cls <= op_class;
            // Any state change clears the counter, so it restarts on entry to FETCH/MEMORY.
            if (state_next != state)
                wait_cnt <= '0;
            else if ((state == ST_FETCH || state == ST_MEMORY) && MEM_TIMEOUT != 0)
                wait_cnt <= wait_cnt + TO_W'(1);
        end
    end

    always_comb begin
        state_next   = state;
        err_next     = err_code;
        imem_req     = 1'b0;
        ir_load      = 1'b0;
        alubuf1_load = 1'b0;
        alubuf2_load = 1'b0;
        alu_load     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        rf_write     = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        error        = 1'b0;
        case (state)
            ST_RESET: state_next = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load    = 1'b1;
                    state_next = ST_DECODE;
                end else if (timeout_hit) begin
                    state_next = ST_ERROR;
                    err_next   = 2'b10;
                end
            end
            ST_DECODE: begin
                if (!stall) begin
                    alubuf1_load = 1'b1;
                    alubuf2_load = 1'b1;
                    if (op_legal) begin
                        state_next = ST_EXECUTE;
                    end else begin
                        state_next = ST_ERROR;
                        err_next   = 2'b01;
                    end
                end
            end
            ST_EXECUTE: begin
                if (!stall) begin
                    alu_load = 1'b1;
                    case (cls)
                        CL_BRANCH: begin
                            pc_load    = branch_taken;
                            pc_inc     = !branch_taken;
                            state_next = ST_FETCH;
                        end
                        CL_LOAD, CL_STORE: state_next = ST_MEMORY;
                        default:           state_next = ST_WRITEBACK;
                    endcase
                end
            end
            ST_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = (cls == CL_STORE);
                if (dmem_ack) begin
                    if (cls == CL_STORE) begin
                        pc_inc     = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_WRITEBACK;
                    end
                end else if (timeout_hit) begin
                    state_next = ST_ERROR;
                    err_next   = 2'b11;
                end
            end
            ST_WRITEBACK: begin
                if (!stall) begin
                    rf_write   = 1'b1;
                    pc_load    = (cls == CL_JUMP);
                    pc_inc     = (cls != CL_JUMP);
                    state_next = ST_FETCH;
                end
            end
            ST_ERROR: begin
                error = 1'b1;
                if (err_clear) begin
                    state_next = ST_RESET;
                    err_next   = 2'b00;
                end
            end
            default: state_next = ST_ERROR;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: table-driven directed vectors for ctrl_seq with MEM_TIMEOUT=4,
// plus hand-written reset sequences.
`default_nettype none

module tb_ctrl_seq;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       imem_ack, dmem_ack, branch_taken, stall, err_clear;
    logic       imem_req, ir_load, alubuf1_load, alubuf2_load, alu_load;
    logic       dmem_req, dmem_we, rf_write, pc_inc, pc_load;
    logic [2:0] state_o;
    logic       error;
    logic [1:0] err_code;
    logic [9:0] strobes;

    int tests = 0;
    int fails = 0;

    ctrl_seq #(.MEM_TIMEOUT(4)) dut (
        .clock(clock), .reset(reset), .opcode(opcode),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .branch_taken(branch_taken),
        .stall(stall), .err_clear(err_clear),
        .imem_req(imem_req), .ir_load(ir_load),
        .alubuf1_load(alubuf1_load), .alubuf2_load(alubuf2_load),
        .alu_load(alu_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_write(rf_write), .pc_inc(pc_inc), .pc_load(pc_load),
        .state_o(state_o), .error(error), .err_code(err_code)
    );

    always #5 clock = ~clock;

    assign strobes = {imem_req, ir_load, alubuf1_load, alubuf2_load, alu_load,
                      dmem_req, dmem_we, rf_write, pc_inc, pc_load};

    localparam logic [9:0] NONE = 10'b0000000000;
    localparam logic [9:0] IREQ = 10'b1000000000;
    localparam logic [9:0] IRL  = 10'b0100000000;
    localparam logic [9:0] AB   = 10'b0011000000;
    localparam logic [9:0] ALUL = 10'b0000100000;
    localparam logic [9:0] DREQ = 10'b0000010000;
    localparam logic [9:0] DWE  = 10'b0000001000;
    localparam logic [9:0] RFW  = 10'b0000000100;
    localparam logic [9:0] PCI  = 10'b0000000010;
    localparam logic [9:0] PCL  = 10'b0000000001;

    localparam logic [6:0] OP_ALU = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_ILL = 7'b1111111;

    typedef struct {
        logic [6:0] op;
        logic       iack, dack, bt, stl, clr;
        logic [2:0] st;
        logic [9:0] stb;
        logic       err;
        logic [1:0] code;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [6:0] op, input logic iack, input logic dack,
                       input logic bt, input logic stl, input logic clr,
                       input logic [2:0] st, input logic [9:0] stb,
                       input logic err, input logic [1:0] code);
        vec_t v;
        v.op = op; v.iack = iack; v.dack = dack; v.bt = bt; v.stl = stl; v.clr = clr;
        v.st = st; v.stb = stb; v.err = err; v.code = code;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [2:0] st, input logic [9:0] stb,
                         input logic err, input logic [1:0] code);
        tests++;
        if (state_o !== st || strobes !== stb || error !== err || err_code !== code) begin
            fails++;
            $display("FAIL %s: got state=%0d strobes=%b error=%b err_code=%b, expected state=%0d strobes=%b error=%b err_code=%b",
                     name, state_o, strobes, error, err_code, st, stb, err, code);
        end
    endtask

    initial begin
        reset = 1'b0; opcode = OP_ILL; imem_ack = 1'b0; dmem_ack = 1'b0;
        branch_taken = 1'b0; stall = 1'b0; err_clear = 1'b0;

        //   op      ia dk bt st cl  state strobes          err code
        add(OP_ILL, 1, 1, 0, 0, 0, 3'd1, NONE,            0, 2'b00); // RESET
        add(OP_ILL, 1, 1, 0, 0, 0, 3'd2, IREQ|IRL,        0, 2'b00); // ALU
        add(OP_ALU, 1, 1, 0, 0, 0, 3'd3, AB,              0, 2'b00);
        add(OP_ILL, 1, 1, 0, 0, 0, 3'd4, ALUL,            0, 2'b00);
        add(OP_ILL, 1, 1, 0, 0, 0, 3'd6, RFW|PCI,         0, 2'b00);
        add(OP_ILL, 1, 1, 0, 0, 0, 3'd2, IREQ|IRL,        0, 2'b00); // LOAD, 3 waits
        add(OP_LD,  1, 1, 0, 0, 0, 3'd3, AB,              0, 2'b00);
        add(OP_ILL, 1, 1, 0, 0, 0, 3'd4, ALUL,            0, 2'b00);
        add(OP_ILL, 1, 0, 0, 0, 0, 3'd5, DREQ,            0, 2'b00);
        add(OP_ILL, 1, 0, 0, 0, 0, 3'd5, DREQ,            0, 2'b00);
        add(OP_ILL, 1, 0, 0, 0, 0, 3'd5, DREQ,            0, 2'b00);
        add(OP_ILL, 1, 1, 0, 0, 0, 3'd5, DREQ,            0, 2'b00); // ack beats timeout
        add(OP_ILL, 1, 1, 0, 0, 0, 3'd6, RFW|PCI,         0, 2'b00);
        add(OP_ILL, 1, 1, 0, 0, 1, 3'd2, IREQ|IRL,        0, 2'b00); // STORE, err_clear ignored
        add(OP_ST,  1, 1, 0, 0, 0, 3'd3, AB,              0, 2'b00);
        add(OP_ILL, 1, 1, 0, 0, 0, 3'd4, ALUL,            0, 2'b00);
        add(OP_ILL, 1, 0, 0, 0, 0, 3'd5, DREQ|DWE,        0, 2'b00);
        add(OP_ILL, 1, 1, 0, 0, 0, 3'd5, DREQ|DWE|PCI,    0, 2'b00);
        add(OP_ILL, 1, 1, 0, 0, 0, 3'd2, IREQ|IRL,        0, 2'b00); // BRANCH taken
        add(OP_BR,  1, 1, 0, 0, 0, 3'd3, AB,              0, 2'b00);
        add(OP_ILL, 1, 1, 1, 0, 0, 3'd4, ALUL|PCL,        0, 2'b00);
        add(OP_ILL, 1, 1, 0, 0, 0, 3'd2, IREQ|IRL,        0, 2'b00); // BRANCH not taken
        add(OP_BR,  1, 1, 0, 0, 0, 3'd3, AB,              0, 2'b00);
        add(OP_ILL, 1, 1, 0, 0, 0, 3'd4, ALUL|PCI,        0, 2'b00);
        add(OP_ILL, 1, 1, 0, 0, 0, 3'd2, IREQ|IRL,        0, 2'b00); // JUMP
        add(OP_JAL, 1, 1, 0, 0, 0, 3'd3, AB,              0, 2'b00);
        add(OP_ILL, 1, 1, 1, 0, 0, 3'd4, ALUL,            0, 2'b00);
        add(OP_ILL, 1, 1, 1, 0, 0, 3'd6, RFW|PCL,         0, 2'b00);
        add(OP_ILL, 1, 1, 0, 0, 0, 3'd2, IREQ|IRL,        0, 2'b00); // stall in EXECUTE
        add(OP_ALU, 1, 1, 0, 0, 0, 3'd3, AB,              0, 2'b00);
        add(OP_ILL, 1, 1, 0, 1, 0, 3'd4, NONE,            0, 2'b00);
        add(OP_ILL, 1, 1, 0, 1, 0, 3'd4, NONE,            0, 2'b00);
        add(OP_ILL, 1, 1, 0, 0, 0, 3'd4, ALUL,            0, 2'b00);
        add(OP_ILL, 1, 1, 0, 0, 0, 3'd6, RFW|PCI,         0, 2'b00);
        add(OP_ILL, 1, 1, 0, 1, 0, 3'd2, IREQ|IRL,        0, 2'b00); // stall ignored in FETCH
        add(OP_ILL, 1, 1, 0, 1, 0, 3'd3, NONE,            0, 2'b00); // stalled DECODE holds
        add(OP_ILL, 1, 1, 0, 0, 0, 3'd3, AB,              0, 2'b00); // illegal opcode
        add(OP_ILL, 1, 1, 0, 0, 0, 3'd0, NONE,            1, 2'b01);
        add(OP_ILL, 1, 1, 0, 0, 1, 3'd0, NONE,            1, 2'b01);
        add(OP_ILL, 0, 0, 0, 0, 0, 3'd1, NONE,            0, 2'b00);
        add(OP_ILL, 0, 0, 0, 0, 0, 3'd2, IREQ,            0, 2'b00); // imem timeout
        add(OP_ILL, 0, 0, 0, 0, 0, 3'd2, IREQ,            0, 2'b00);
        add(OP_ILL, 0, 0, 0, 0, 0, 3'd2, IREQ,            0, 2'b00);
        add(OP_ILL, 0, 0, 0, 0, 0, 3'd2, IREQ,            0, 2'b00);
        add(OP_ILL, 0, 0, 0, 0, 0, 3'd0, NONE,            1, 2'b10);
        add(OP_ILL, 0, 0, 0, 0, 1, 3'd0, NONE,            1, 2'b10);
        add(OP_ILL, 0, 0, 0, 0, 0, 3'd1, NONE,            0, 2'b00);
        add(OP_ILL, 0, 0, 0, 0, 0, 3'd2, IREQ,            0, 2'b00); // ack on 4th cycle
        add(OP_ILL, 0, 0, 0, 0, 0, 3'd2, IREQ,            0, 2'b00);
        add(OP_ILL, 0, 0, 0, 0, 0, 3'd2, IREQ,            0, 2'b00);
        add(OP_ILL, 1, 0, 0, 0, 0, 3'd2, IREQ|IRL,        0, 2'b00);
        add(OP_LD,  1, 0, 0, 0, 0, 3'd3, AB,              0, 2'b00); // dmem timeout
        add(OP_ILL, 1, 0, 0, 0, 0, 3'd4, ALUL,            0, 2'b00);
        add(OP_ILL, 1, 0, 0, 0, 0, 3'd5, DREQ,            0, 2'b00);
        add(OP_ILL, 1, 0, 0, 0, 0, 3'd5, DREQ,            0, 2'b00);
        add(OP_ILL, 1, 0, 0, 0, 0, 3'd5, DREQ,            0, 2'b00);
        add(OP_ILL, 1, 0, 0, 0, 0, 3'd5, DREQ,            0, 2'b00);
        add(OP_ILL, 1, 0, 0, 0, 0, 3'd0, NONE,            1, 2'b11);
        add(OP_ILL, 1, 0, 0, 0, 1, 3'd0, NONE,            1, 2'b11);
        add(OP_ILL, 1, 0, 0, 0, 0, 3'd1, NONE,            0, 2'b00);
        add(OP_ILL, 1, 0, 0, 0, 0, 3'd2, IREQ|IRL,        0, 2'b00); // into MEMORY for reset
        add(OP_LD,  1, 0, 0, 0, 0, 3'd3, AB,              0, 2'b00);
        add(OP_ILL, 1, 0, 0, 0, 0, 3'd4, ALUL,            0, 2'b00);
        add(OP_ILL, 1, 0, 0, 0, 0, 3'd5, DREQ,            0, 2'b00);

        // Reset held from time zero.
        @(negedge clock);
        @(negedge clock);
        #1 check("reset_state", 3'd1, NONE, 1'b0, 2'b00);

        foreach (vq[i]) begin
            @(negedge clock);
            reset = 1'b1;
            opcode = vq[i].op; imem_ack = vq[i].iack; dmem_ack = vq[i].dack;
            branch_taken = vq[i].bt; stall = vq[i].stl; err_clear = vq[i].clr;
            #1 check($sformatf("vec%0d", i), vq[i].st, vq[i].stb, vq[i].err, vq[i].code);
        end

        // Async reset mid-MEMORY, asserted away from any clock edge.
        #2 dmem_ack = 1'b1;
        reset = 1'b0;
        #1 check("async_reset_immediate", 3'd1, NONE, 1'b0, 2'b00);
        @(posedge clock);
        #1 check("async_reset_held", 3'd1, NONE, 1'b0, 2'b00);
        @(negedge clock);
        reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        #1 check("reset_release", 3'd1, NONE, 1'b0, 2'b00);
        @(posedge clock);
        #1 check("first_fetch", 3'd2, IREQ, 1'b0, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
